// File: rtl/safe_lock_ctrl.sv
// Keypad safe controller: set/confirm an N-digit code while open, lock until the
// same code is entered again, with failed-attempt counting and timed lockout.
//
// state          | meaning
// S_OPEN_SET     | open, collecting a new code
// S_OPEN_CONFIRM | open, collecting the confirmation of the new code
// S_LOCKED       | closed, waiting for the stored code
// S_LOCKOUT      | closed, too many wrong codes, all keys ignored until timer expires
module safe_lock_ctrl #(
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3:0]                         invalue,
    output logic                               lock,
    output logic                               green,
    output logic                               blue,
    output logic                               red,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int EW = CODE_LEN * 4;
    localparam logic [CW-1:0] FULL       = CW'(CODE_LEN);
    localparam logic [FW-1:0] MAXF       = FW'(MAX_FAILS);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OPEN_SET     = 3'd0,
        S_OPEN_CONFIRM = 3'd1,
        S_LOCKED       = 3'd2,
        S_LOCKOUT      = 3'd3
    } state_t;

    state_t          state, state_nxt;
    logic [EW-1:0]   entry, entry_nxt;
    logic [EW-1:0]   code, code_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [FW-1:0]   fail_nxt, fail_inc;
    logic [TW-1:0]   timer, timer_nxt;
    logic            is_digit, is_enter, is_clear, full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_OPEN_SET;
            entry      <= '0;
            code       <= '0;
            count      <= '0;
            timer      <= '0;
            fail_count <= '0;
            lock       <= 1'b0;
            green      <= 1'b1;
            blue       <= 1'b0;
            red        <= 1'b0;
        end else begin
            state      <= state_nxt;
            entry      <= entry_nxt;
            code       <= code_nxt;
            count      <= count_nxt;
            timer      <= timer_nxt;
            fail_count <= fail_nxt;
            // Indicators follow the state being entered so they line up with it.
            lock       <= (state_nxt == S_LOCKED) || (state_nxt == S_LOCKOUT);
            green      <= (state_nxt == S_OPEN_SET) || (state_nxt == S_OPEN_CONFIRM);
            blue       <= (state_nxt == S_LOCKED);
            red        <= (state_nxt == S_LOCKOUT);
        end
    end

    always_comb begin
        state_nxt = state;
        entry_nxt = entry;
        code_nxt  = code;
        count_nxt = count;
        fail_nxt  = fail_count;
        timer_nxt = timer;
        is_digit  = (invalue < 4'd10);
        is_enter  = (invalue == 4'd10);
        is_clear  = (invalue == 4'd11);
        full      = (count == FULL);
        fail_inc  = fail_count + 1'b1;

        case (state)
            S_OPEN_SET, S_OPEN_CONFIRM, S_LOCKED: begin
                if (is_digit && !full) begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (count == CW'(i)) entry_nxt[i*4 +: 4] = invalue;
                    end
                    count_nxt = count + 1'b1;
                end else if (is_clear) begin
                    entry_nxt = '0;
                    count_nxt = '0;
                    if (state == S_OPEN_CONFIRM) state_nxt = S_OPEN_SET;
                end else if (is_enter && full) begin
                    entry_nxt = '0;
                    count_nxt = '0;
                    if (state == S_OPEN_SET) begin
                        code_nxt  = entry;
                        state_nxt = S_OPEN_CONFIRM;
                    end else if (state == S_OPEN_CONFIRM) begin
                        state_nxt = (entry == code) ? S_LOCKED : S_OPEN_SET;
                    end else if (entry == code) begin
                        state_nxt = S_OPEN_SET;
                        fail_nxt  = '0;
                    end else begin
                        fail_nxt = fail_inc;
                        if (fail_inc == MAXF) begin
                            state_nxt = S_LOCKOUT;
                            timer_nxt = TIMER_LOAD;
                        end
                    end
                end
            end
            S_LOCKOUT: begin
                if (timer == '0) begin
                    state_nxt = S_LOCKED;
                    fail_nxt  = '0;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                state_nxt = S_OPEN_SET;
                entry_nxt = '0;
                count_nxt = '0;
                fail_nxt  = '0;
                timer_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed bench for safe_lock_ctrl with CODE_LEN=4, MAX_FAILS=3, LOCKOUT_CYCLES=8.
module tb_safe_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] invalue;
    logic       lock, green, blue, red;
    logic [1:0] fail_count;
    logic [5:0] st;
    int         checks = 0;
    int         failures = 0;

    // Status word {lock, green, blue, red, fail_count}
    localparam logic [5:0] ST_OPEN    = 6'b0100_00;
    localparam logic [5:0] ST_LOCKED0 = 6'b1010_00;
    localparam logic [5:0] ST_LOCKED1 = 6'b1010_01;
    localparam logic [5:0] ST_LOCKED2 = 6'b1010_10;
    localparam logic [5:0] ST_LOCKOUT = 6'b1001_11;

    safe_lock_ctrl #(.CODE_LEN(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .invalue(invalue),
        .lock(lock), .green(green), .blue(blue), .red(red), .fail_count(fail_count)
    );

    always #5 clk = ~clk;
    assign st = {lock, green, blue, red, fail_count};

    task automatic press(input logic [3:0] k);
        invalue = k;
        @(posedge clk);
        #1 invalue = 4'd13;
    endtask

    task automatic enter(input logic [3:0] a, b, c, d);
        press(a); press(b); press(c); press(d); press(4'd10);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; invalue = 4'd13;
        idle(2);
        rst = 1'b0;
        checks++;
        if (st !== ST_OPEN) begin failures++; $display("FAIL reset_state got=%b exp=%b", st, ST_OPEN); end
    endtask

    task automatic test_set_and_lock();
        do_reset();
        enter(1, 2, 3, 4);
        checks++;
        if (st !== ST_OPEN) begin failures++; $display("FAIL set_still_open got=%b exp=%b", st, ST_OPEN); end
        enter(1, 2, 3, 4);
        checks++;
        if (st !== ST_LOCKED0) begin failures++; $display("FAIL confirm_locks got=%b exp=%b", st, ST_LOCKED0); end
    endtask

    task automatic test_confirm_mismatch();
        do_reset();
        enter(1, 2, 3, 4);
        enter(1, 2, 3, 5);
        checks++;
        if (st !== ST_OPEN) begin failures++; $display("FAIL confirm_mismatch got=%b exp=%b", st, ST_OPEN); end
        enter(5, 6, 7, 8);
        enter(5, 6, 7, 8);
        checks++;
        if (st !== ST_LOCKED0) begin failures++; $display("FAIL relock_5678 got=%b exp=%b", st, ST_LOCKED0); end
        enter(1, 2, 3, 4);
        checks++;
        if (st !== ST_LOCKED1) begin failures++; $display("FAIL old_code_rejected got=%b exp=%b", st, ST_LOCKED1); end
        enter(5, 6, 7, 8);
        checks++;
        if (st !== ST_OPEN) begin failures++; $display("FAIL open_5678 got=%b exp=%b", st, ST_OPEN); end
    endtask

    task automatic test_short_entry();
        do_reset();
        enter(1, 2, 3, 4); enter(1, 2, 3, 4);
        press(1); press(2); press(3); press(4'd10);
        checks++;
        if (st !== ST_LOCKED0) begin failures++; $display("FAIL short_enter_ignored got=%b exp=%b", st, ST_LOCKED0); end
        press(4); press(4'd10);
        checks++;
        if (st !== ST_OPEN) begin failures++; $display("FAIL short_then_complete got=%b exp=%b", st, ST_OPEN); end
    endtask

    task automatic test_lockout();
        do_reset();
        enter(1, 2, 3, 4); enter(1, 2, 3, 4);
        enter(0, 0, 0, 0);
        checks++;
        if (st !== ST_LOCKED1) begin failures++; $display("FAIL fail_1 got=%b exp=%b", st, ST_LOCKED1); end
        enter(0, 0, 0, 0);
        checks++;
        if (st !== ST_LOCKED2) begin failures++; $display("FAIL fail_2 got=%b exp=%b", st, ST_LOCKED2); end
        enter(0, 0, 0, 0);
        checks++;
        if (st !== ST_LOCKOUT) begin failures++; $display("FAIL lockout_entry got=%b exp=%b", st, ST_LOCKOUT); end
        enter(1, 2, 3, 4);
        idle(2);
        checks++;
        if (st !== ST_LOCKOUT) begin failures++; $display("FAIL lockout_cycle7 got=%b exp=%b", st, ST_LOCKOUT); end
        idle(1);
        checks++;
        if (st !== ST_LOCKED0) begin failures++; $display("FAIL lockout_exit got=%b exp=%b", st, ST_LOCKED0); end
        enter(1, 2, 3, 4);
        checks++;
        if (st !== ST_OPEN) begin failures++; $display("FAIL open_after_lockout got=%b exp=%b", st, ST_OPEN); end
    endtask

    task automatic test_clear_and_overflow();
        do_reset();
        enter(1, 2, 3, 4); enter(1, 2, 3, 4);
        press(1); press(2); press(4'd11);
        enter(1, 2, 3, 4);
        checks++;
        if (st !== ST_OPEN) begin failures++; $display("FAIL clear_then_code got=%b exp=%b", st, ST_OPEN); end
        enter(1, 2, 3, 4); enter(1, 2, 3, 4);
        press(1); press(2); press(3); press(4); press(9); press(4'd10);
        checks++;
        if (st !== ST_OPEN) begin failures++; $display("FAIL fifth_digit_dropped got=%b exp=%b", st, ST_OPEN); end
    endtask

    task automatic test_clear_in_confirm();
        do_reset();
        enter(1, 2, 3, 4);
        press(4'd11);
        enter(5, 6, 7, 8);
        enter(5, 6, 7, 8);
        checks++;
        if (st !== ST_LOCKED0) begin failures++; $display("FAIL clear_returns_to_set got=%b exp=%b", st, ST_LOCKED0); end
    endtask

    task automatic test_ignored_keys();
        do_reset();
        press(1); press(2); press(4'd12); press(3); press(4'd14); press(4'd15); press(4); press(4'd10);
        enter(1, 2, 3, 4);
        checks++;
        if (st !== ST_LOCKED0) begin failures++; $display("FAIL ignored_keys got=%b exp=%b", st, ST_LOCKED0); end
    endtask

    task automatic test_reset_in_lockout();
        do_reset();
        enter(1, 2, 3, 4); enter(1, 2, 3, 4);
        enter(0, 0, 0, 0); enter(0, 0, 0, 0); enter(0, 0, 0, 0);
        rst = 1'b1; invalue = 4'd10;
        @(posedge clk);
        #1 rst = 1'b0; invalue = 4'd13;
        checks++;
        if (st !== ST_OPEN) begin failures++; $display("FAIL reset_in_lockout got=%b exp=%b", st, ST_OPEN); end
        enter(9, 9, 9, 9); enter(9, 9, 9, 9);
        checks++;
        if (st !== ST_LOCKED0) begin failures++; $display("FAIL lock_after_reset got=%b exp=%b", st, ST_LOCKED0); end
    endtask

    initial begin
        test_reset();
        test_set_and_lock();
        test_confirm_mismatch();
        test_short_entry();
        test_lockout();
        test_clear_and_overflow();
        test_clear_in_confirm();
        test_ignored_keys();
        test_reset_in_lockout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
